// File: rtl/rv32m_div_unit.sv
// rv32m_div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Radix-2 restoring divider, 32 iterations plus a sign-fix cycle. Results for
// divide-by-zero and signed overflow come straight from the accept edge.
module rv32m_div_unit (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        FLUSH,
    input  logic [1:0]  OP,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_op;
    logic        r_neg_q, r_neg_r;
    logic [31:0] r_quo, r_rem, r_dvs, r_result;
    logic [4:0]  r_cnt;
    logic        r_busy, r_done;

    // OP[0]=0 means signed (DIV/REM); OP[1]=1 means remainder (REM/REMU)
    logic        w_signed, w_is_rem, w_div0, w_ovf, w_special, w_accept;
    logic [31:0] w_abs1, w_abs2, w_spec_val;
    logic [32:0] w_shift, w_trial;
    logic [31:0] w_q_fix, w_r_fix;

    assign w_signed  = ~OP[0];
    assign w_is_rem  = OP[1];
    assign w_abs1    = (w_signed && DATA1[31]) ? -DATA1 : DATA1;
    assign w_abs2    = (w_signed && DATA2[31]) ? -DATA2 : DATA2;
    assign w_div0    = (DATA2 == 32'd0);
    assign w_ovf     = w_signed && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
    assign w_special = w_div0 || w_ovf;
    assign w_spec_val = w_div0 ? (w_is_rem ? DATA1 : 32'hFFFF_FFFF)
                               : (w_is_rem ? 32'd0 : 32'h8000_0000);
    assign w_accept  = START && !FLUSH && (r_state == S_IDLE || r_state == S_DONE);

    // One restoring step: shift the next dividend bit into the partial remainder
    assign w_shift = {r_rem, r_quo[31]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; FLUSH overrides everything, including a new START
    always_comb begin
        w_next = r_state;
        if (FLUSH) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) w_next = w_special ? S_DONE : S_CALC;
                    else       w_next = S_IDLE;
                end
                S_CALC:  if (r_cnt == 5'd0) w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, sign fix and result hold
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_op     <= 2'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_dvs    <= 32'd0;
            r_cnt    <= 5'd0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_op    <= OP;
            r_neg_q <= w_signed && (DATA1[31] ^ DATA2[31]);
            r_neg_r <= w_signed && DATA1[31];
            r_quo   <= w_abs1;
            r_rem   <= 32'd0;
            r_dvs   <= w_abs2;
            r_cnt   <= 5'd31;
            if (w_special) r_result <= w_spec_val;
        end else if (!FLUSH && r_state == S_CALC) begin
            if (!w_trial[32]) begin
                r_rem <= w_trial[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
            r_cnt <= r_cnt - 5'd1;
        end else if (!FLUSH && r_state == S_FIX) begin
            r_result <= r_op[1] ? w_r_fix : w_q_fix;
        end
    end

    // Registered handshake outputs, decoded from the upcoming state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_CALC) || (w_next == S_FIX);
            r_done <= (w_next == S_DONE);
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign RESULT = r_result;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Directed and back-to-back random checks for rv32m_div_unit.
module tb_rv32m_div_unit;

    logic        CLK, RESET_N, START, FLUSH;
    logic [1:0]  OP;
    logic [31:0] DATA1, DATA2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int n_cmp = 0;
    int n_bad = 0;

    rv32m_div_unit dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .FLUSH(FLUSH),
        .OP(OP), .DATA1(DATA1), .DATA2(DATA2),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          busy;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M reference semantics
    function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] r;
        logic ovf;
        sa = a; sb = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0: if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = 32'h8000_0000; else r = sa / sb;
            2'd1: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
            2'd2: if (b == 0) r = a; else if (ovf) r = 32'd0; else r = sa % sb;
            default: if (b == 0) r = a; else r = a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_spec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one request and wait (bounded) for DONE; counts latency and BUSY cycles
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bc);
        @(negedge CLK);
        OP = op; DATA1 = a; DATA2 = b; START = 1'b1;
        @(negedge CLK);
        START = 1'b0; OP = ~op; DATA1 = $urandom; DATA2 = $urandom;
        lat = 1; bc = 0;
        while (!DONE && lat < 100) begin
            if (BUSY) bc++;
            @(negedge CLK);
            lat++;
        end
        res = RESULT;
    endtask

    initial begin
        logic [31:0] res, a, b, exp;
        logic [1:0]  op;
        int lat, bc, nd, elat;

        tv[0]  = '{2'd0, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34, 33};
        tv[1]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34, 33};
        tv[2]  = '{2'd1, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 34, 33};
        tv[3]  = '{2'd3, 32'd100,       32'd7,          32'd2,         34, 33};
        tv[4]  = '{2'd1, 32'd100,       32'd7,          32'd14,        34, 33};
        tv[5]  = '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         34, 33};
        tv[6]  = '{2'd0, 32'h8000_0000, 32'd2,          32'hC000_0000, 34, 33};
        tv[7]  = '{2'd0, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 1,  0};
        tv[8]  = '{2'd1, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 1,  0};
        tv[9]  = '{2'd2, 32'h1234_5678, 32'd0,          32'h1234_5678, 1,  0};
        tv[10] = '{2'd3, 32'h1234_5678, 32'd0,          32'h1234_5678, 1,  0};
        tv[11] = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1,  0};
        tv[12] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         1,  0};

        RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0; OP = 2'd0; DATA1 = '0; DATA2 = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        RESET_N = 1'b1;

        foreach (tv[i]) begin
            run_op(tv[i].op, tv[i].a, tv[i].b, res, lat, bc);
            chk($sformatf("vec%0d_result", i), res, tv[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bc, tv[i].busy);
            @(negedge CLK);
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, DONE}, 32'd0);
        end

        // START pulses while busy must be ignored: one DONE, original operands
        @(negedge CLK);
        OP = 2'd1; DATA1 = 32'd1000; DATA2 = 32'd10; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        nd = 0;
        for (int c = 0; c < 45; c++) begin
            if (DONE) nd++;
            START = (c >= 3 && c < 20 && c[0]);
            OP = 2'd3; DATA1 = $urandom; DATA2 = 32'd0;
            @(negedge CLK);
        end
        START = 1'b0;
        chk("start_while_busy_done_count", nd, 32'd1);
        chk("start_while_busy_result", RESULT, 32'd100);

        // FLUSH 10 cycles into a DIV: no DONE, RESULT retained
        @(negedge CLK);
        OP = 2'd0; DATA1 = 32'd50; DATA2 = 32'd5; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("flush_busy", {31'd0, BUSY}, 32'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (DONE || BUSY) nd++;
            @(negedge CLK);
        end
        chk("flush_no_activity", nd, 32'd0);
        chk("flush_result_kept", RESULT, 32'd100);

        // FLUSH together with START in IDLE: nothing accepted
        OP = 2'd0; DATA1 = 32'd9; DATA2 = 32'd0; START = 1'b1; FLUSH = 1'b1;
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b0;
        chk("flush_start_done", {31'd0, DONE}, 32'd0);
        chk("flush_start_busy", {31'd0, BUSY}, 32'd0);
        chk("flush_start_result", RESULT, 32'd100);

        // Asynchronous reset mid-CALC
        OP = 2'd0; DATA1 = 32'd1000; DATA2 = 32'd3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_done", {31'd0, DONE}, 32'd0);
        chk("midrst_result", RESULT, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (DONE || BUSY) nd++;
            @(negedge CLK);
        end
        chk("midrst_no_done", nd, 32'd0);

        // Back-to-back: START held, new operands supplied in each DONE cycle
        op = 2'($urandom_range(0, 3)); a = pick(); b = pick();
        OP = op; DATA1 = a; DATA2 = b; START = 1'b1;
        for (int i = 0; i < 100; i++) begin
            exp  = ref_fn(op, a, b);
            elat = is_spec(op, a, b) ? 1 : 34;
            lat = 0;
            do begin
                @(negedge CLK);
                lat++;
            end while (!DONE && lat < 100);
            chk($sformatf("b2b%0d_result op=%0d a=%h b=%h", i, op, a, b), RESULT, exp);
            chk($sformatf("b2b%0d_latency", i), lat, elat);
            if (i == 99) begin
                START = 1'b0;
            end else begin
                op = 2'($urandom_range(0, 3)); a = pick(); b = pick();
                OP = op; DATA1 = a; DATA2 = b;
            end
        end
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
